// File: rtl/alu_pkg.sv
// Shared encodings for the chunked sequential ALU.
// Op codes follow the classic a_invert/b_invert/op cell scheme.
package alu_pkg;

  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_ADD  = 2'b10;
  localparam logic [1:0] OP_LESS = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

endpackage

// File: rtl/alu_slice.sv
// Combinational CHUNK-bit ripple slice of the ALU.
// Adder path always evaluated so flags exist for every op.
module alu_slice
  import alu_pkg::*;
#(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             a_invert,
  input  logic             b_invert,
  input  logic             cin,
  input  logic [1:0]       op,
  output logic [CHUNK-1:0] y,
  output logic             cout,
  output logic             c_msb_in,
  output logic             sum_msb
);

  logic [CHUNK-1:0] w_a;
  logic [CHUNK-1:0] w_b;
  logic [CHUNK-1:0] w_s;

  assign w_a = a ^ {CHUNK{a_invert}};
  assign w_b = b ^ {CHUNK{b_invert}};

  always_comb begin
    logic c;
    c        = cin;
    w_s      = '0;
    c_msb_in = 1'b0;
    for (int i = 0; i < CHUNK; i++) begin
      w_s[i] = w_a[i] ^ w_b[i] ^ c;
      if (i == CHUNK - 1) c_msb_in = c;
      c = (w_a[i] & w_b[i]) | (c & (w_a[i] ^ w_b[i]));
    end
    cout = c;
  end

  assign sum_msb = w_s[CHUNK-1];

  always_comb begin
    y = '0;
    unique case (1'b1)
      op == OP_AND:  y = w_a & w_b;
      op == OP_OR:   y = w_a | w_b;
      op == OP_ADD:  y = w_s;
      op == OP_LESS: y = '0;
    endcase
  end

endmodule

// File: rtl/alu_chunked_seq.sv
// Multi-cycle ALU: operands captured once, then CHUNK bits per
// cycle through one shared slice with a registered carry.
module alu_chunked_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             a_invert,
  input  logic             b_invert,
  input  logic             carry_in,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             set,
  output logic             zero,
  output logic             done
);

  localparam int N  = WIDTH / CHUNK;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_shadow;
  logic             r_ainv;
  logic             r_binv;
  logic [1:0]       r_op;
  logic             r_carry;
  logic             r_cmsb;
  logic             r_smsb;
  logic [IW-1:0]    r_idx;
  logic [WIDTH-1:0] r_result;
  logic             r_cout;
  logic             r_ovf;
  logic             r_set;
  logic             r_zero;
  logic             r_done;

  logic [31:0]      w_base;
  logic [CHUNK-1:0] w_ca;
  logic [CHUNK-1:0] w_cb;
  logic [CHUNK-1:0] w_y;
  logic             w_cout;
  logic             w_cmsb;
  logic             w_smsb;
  logic             w_last;
  logic             w_ovf;
  logic             w_set;
  logic [WIDTH-1:0] w_final;

  assign w_base = 32'(r_idx) * 32'(CHUNK);
  assign w_ca   = r_a[w_base +: CHUNK];
  assign w_cb   = r_b[w_base +: CHUNK];
  assign w_last = (r_idx == IW'(N - 1));

  alu_slice #(
    .CHUNK(CHUNK)
  ) u_slice (
    .a        (w_ca),
    .b        (w_cb),
    .a_invert (r_ainv),
    .b_invert (r_binv),
    .cin      (r_carry),
    .op       (r_op),
    .y        (w_y),
    .cout     (w_cout),
    .c_msb_in (w_cmsb),
    .sum_msb  (w_smsb)
  );

  // after the last chunk r_carry holds the carry out of the MSB
  assign w_ovf   = r_cmsb ^ r_carry;
  assign w_set   = r_smsb ^ w_ovf;
  assign w_final = (r_op == OP_LESS) ? WIDTH'(w_set) : r_shadow;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_shadow <= '0;
      r_ainv   <= 1'b0;
      r_binv   <= 1'b0;
      r_op     <= OP_AND;
      r_carry  <= 1'b0;
      r_cmsb   <= 1'b0;
      r_smsb   <= 1'b0;
      r_idx    <= '0;
      r_result <= '0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
      r_set    <= 1'b0;
      r_zero   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_ainv  <= a_invert;
            r_binv  <= b_invert;
            r_op    <= op;
            r_carry <= carry_in;
            r_idx   <= '0;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_shadow[w_base +: CHUNK] <= w_y;
          r_carry <= w_cout;
          if (w_last) begin
            r_cmsb  <= w_cmsb;
            r_smsb  <= w_smsb;
            r_state <= FINISH;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        FINISH: begin
          r_result <= w_final;
          r_cout   <= r_carry;
          r_ovf    <= w_ovf;
          r_set    <= w_set;
          r_zero   <= (w_final == '0);
          r_done   <= 1'b1;
          r_state  <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ready     = (r_state == IDLE);
  assign result    = r_result;
  assign carry_out = r_cout;
  assign overflow  = r_ovf;
  assign set       = r_set;
  assign zero      = r_zero;
  assign done      = r_done;

endmodule
